// File: rtl/complex_wb_queue.sv
// complex_wb_queue
//
// Small circular FIFO that parks complex-FU results until the shared
// writeback port is free. The simple lane owns the port whenever
// simpleValid_i is high, so the queue only drains on cycles the simple lane
// leaves idle. If the simple lane hogs the port for STARVE_LIMIT cycles in a
// row while results are waiting, starve_o asks issue to leave the simple lane
// idle for a cycle.
//
// Packet layout (PKT_W bits): bit PKT_W-1 is the valid flag, bits PKT_W-2:0
// are payload. Only the payload is stored; the valid flag is regenerated on
// the output.
//
// Ports
//   clk              sole clock, rising edge
//   reset            synchronous, active-high; wins over everything else
//   flush_i          discard every queued packet and the incoming one
//   simpleValid_i    simple lane is using the writeback port this cycle
//   complexPacket_i  incoming complex-FU packet (valid in MSB)
//   wbPacket_o       head packet when it is being written back, else 0
//   complexStall_o   queue full; complex FU must hold its result
//   starve_o         registered request to idle the simple lane
//   count_o          occupancy, 0..DEPTH
//   overflow_o       sticky: a packet arrived while full and not draining
//
// Handshake: the complex FU presents a packet with valid=1; it is taken on
// any clock edge where complexStall_o is low, or where it is high but the
// head is leaving in the same cycle. A packet presented while full and not
// draining is lost and flagged on overflow_o. There is no ready on the
// writeback side: a valid wbPacket_o is consumed in the cycle it appears.
//
// DEPTH must be a power of two and at least 2 so the pointers wrap for free.

module complex_wb_queue #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int PKT_W        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush_i,
    input  logic                    simpleValid_i,
    input  logic [PKT_W-1:0]        complexPacket_i,
    output logic [PKT_W-1:0]        wbPacket_o,
    output logic                    complexStall_o,
    output logic                    starve_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT) + 1;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [PKT_W-2:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starve_cnt;
    logic [SW-1:0]    starve_cnt_nxt;
    logic             overflow_q;
    logic             starve_q;

    logic full;
    logic empty;
    logic deq;
    logic enq_req;
    logic enq;
    logic drop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign deq     = !empty && !simpleValid_i && !flush_i;
    assign enq_req = complexPacket_i[PKT_W-1] && !flush_i;
    // A full queue can still take a packet when the head leaves this cycle.
    assign enq     = enq_req && (!full || deq);
    assign drop    = enq_req && full && !deq;

    // Starve counter counts only cycles where work is waiting and the simple
    // lane holds the port; any drain, empty queue or flush restarts it.
    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (flush_i || deq || empty) begin
            starve_cnt_nxt = '0;
        end else if (simpleValid_i && (starve_cnt != STARVE_MAX)) begin
            starve_cnt_nxt = starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            starve_cnt <= '0;
            starve_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
            // Tracks the counter register: high exactly while it sits at the
            // limit, low the cycle after it clears.
            starve_q   <= (starve_cnt_nxt == STARVE_MAX);
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (flush_i) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (enq) begin
                    tail <= tail + PW'(1);
                end
                if (deq) begin
                    head <= head + PW'(1);
                end
                if (enq && !deq) begin
                    count <= count + CW'(1);
                end else if (deq && !enq) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    // Storage is not reset; head/tail/count decide what is live, so stale
    // slots are never presented.
    always_ff @(posedge clk) begin
        if (enq && !reset) begin
            mem[tail] <= complexPacket_i[PKT_W-2:0];
        end
    end

    // Read is from registered state only, so a packet accepted this cycle
    // cannot appear until the next one.
    assign wbPacket_o     = deq ? {1'b1, mem[head]} : '0;
    assign complexStall_o = full;
    assign starve_o       = starve_q;
    assign count_o        = count;
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_complex_wb_queue.sv
module tb_complex_wb_queue;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;
    localparam int PKT_W        = 16;

    // clock / reset
    logic clk;
    logic reset;
    logic flush_i;
    logic simpleValid_i;
    logic [PKT_W-1:0] complexPacket_i;
    logic [PKT_W-1:0] wbPacket_o;
    logic complexStall_o;
    logic starve_o;
    logic [2:0] count_o;
    logic overflow_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    complex_wb_queue #(
        .DEPTH(DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT),
        .PKT_W(PKT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush_i(flush_i),
        .simpleValid_i(simpleValid_i),
        .complexPacket_i(complexPacket_i),
        .wbPacket_o(wbPacket_o),
        .complexStall_o(complexStall_o),
        .starve_o(starve_o),
        .count_o(count_o),
        .overflow_o(overflow_o)
    );

    // scoreboard state
    int compared   = 0;
    int mismatched = 0;
    logic [PKT_W-1:0] exp_q[$];

    typedef struct {
        logic             fl;
        logic             sv;
        logic [PKT_W-1:0] pkt;
        logic [PKT_W-1:0] wb;
        logic [2:0]       cnt;
        logic             stall;
        logic             starve;
        logic             ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [PKT_W-1:0] p(input int x);
        logic [31:0] v;
        v = x;
        return {1'b1, v[PKT_W-2:0]};
    endfunction

    function automatic vec_t mk(input logic fl, input logic sv,
                                input logic [PKT_W-1:0] pkt, input logic [PKT_W-1:0] wb,
                                input int cnt, input logic stall,
                                input logic starve, input logic ovf);
        vec_t t;
        t.fl = fl; t.sv = sv; t.pkt = pkt; t.wb = wb;
        t.cnt = 3'(cnt); t.stall = stall; t.starve = starve; t.ovf = ovf;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // driver: inputs are applied just after a rising edge
    task automatic drive(input logic fl, input logic sv, input logic [PKT_W-1:0] pkt);
        flush_i         = fl;
        simpleValid_i   = sv;
        complexPacket_i = pkt;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        drive(t.fl, t.sv, t.pkt);
        @(negedge clk);
        check($sformatf("vec%0d_wb", idx),     32'(wbPacket_o),     32'(t.wb));
        check($sformatf("vec%0d_count", idx),  32'(count_o),        32'(t.cnt));
        check($sformatf("vec%0d_stall", idx),  32'(complexStall_o), 32'(t.stall));
        check($sformatf("vec%0d_starve", idx), 32'(starve_o),       32'(t.starve));
        check($sformatf("vec%0d_ovf", idx),    32'(overflow_o),     32'(t.ovf));
        next_cycle();
    endtask

    initial begin
        int sz;
        logic deq_exp;
        logic exp_ovf;
        logic fl, sv;
        logic [PKT_W-1:0] pkt;
        int seq;

        reset = 1'b1;
        drive(1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_wb",     32'(wbPacket_o),     32'd0);
        check("reset_count",  32'(count_o),        32'd0);
        check("reset_stall",  32'(complexStall_o), 32'd0);
        check("reset_starve", 32'(starve_o),       32'd0);
        check("reset_ovf",    32'(overflow_o),     32'd0);
        next_cycle();
        reset = 1'b0;

        // fl, sv, pkt, exp wb, count, stall, starve, ovf (values before the edge)
        vecs.push_back(mk(0, 0, p(1), '0,    0, 0, 0, 0)); // single packet, latency 1
        vecs.push_back(mk(0, 0, '0,   p(1),  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, '0,   '0,    0, 0, 0, 0));
        vecs.push_back(mk(0, 1, p(2), '0,    0, 0, 0, 0)); // fill while simple lane busy
        vecs.push_back(mk(0, 1, p(3), '0,    1, 0, 0, 0));
        vecs.push_back(mk(0, 1, p(4), '0,    2, 0, 0, 0));
        vecs.push_back(mk(0, 1, p(5), '0,    3, 0, 0, 0));
        vecs.push_back(mk(0, 1, '0,   '0,    4, 1, 0, 0));
        vecs.push_back(mk(0, 1, p(6), '0,    4, 1, 0, 0)); // dropped
        vecs.push_back(mk(0, 1, '0,   '0,    4, 1, 0, 1));
        vecs.push_back(mk(0, 0, p(7), p(2),  4, 1, 0, 1)); // full, enq+deq
        vecs.push_back(mk(0, 0, '0,   p(3),  4, 1, 0, 1));
        vecs.push_back(mk(0, 0, '0,   p(4),  3, 0, 0, 1));
        vecs.push_back(mk(0, 0, '0,   p(5),  2, 0, 0, 1));
        vecs.push_back(mk(0, 0, '0,   p(7),  1, 0, 0, 1));
        vecs.push_back(mk(0, 0, '0,   '0,    0, 0, 0, 1));
        vecs.push_back(mk(0, 1, p(8), '0,    0, 0, 0, 1)); // starvation
        for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 1, '0, '0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, '0,   '0,    1, 0, 1, 1));
        vecs.push_back(mk(0, 0, '0,   p(8),  1, 0, 1, 1));
        vecs.push_back(mk(0, 0, '0,   '0,    0, 0, 0, 1));
        vecs.push_back(mk(0, 1, p(9), '0,    0, 0, 0, 1)); // flush with 3 queued
        vecs.push_back(mk(0, 1, p(10), '0,   1, 0, 0, 1));
        vecs.push_back(mk(0, 1, p(11), '0,   2, 0, 0, 1));
        vecs.push_back(mk(1, 0, p(12), '0,   3, 0, 0, 1));
        vecs.push_back(mk(0, 0, '0,   '0,    0, 0, 0, 1));
        vecs.push_back(mk(0, 0, p(13), '0,   0, 0, 0, 1));
        vecs.push_back(mk(0, 0, '0,   p(13), 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, '0,   '0,    0, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // reset together with flush on a full queue
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, p(20 + i));
            next_cycle();
        end
        @(negedge clk);
        check("prefill_count", 32'(count_o), 32'd4);
        next_cycle();
        reset = 1'b1;
        drive(1'b1, 1'b0, p(30));
        @(negedge clk);
        check("rstflush_wb", 32'(wbPacket_o), 32'd0);
        next_cycle();
        reset = 1'b0;
        drive(1'b0, 1'b0, '0);
        @(negedge clk);
        check("post_rst_wb",     32'(wbPacket_o),     32'd0);
        check("post_rst_count",  32'(count_o),        32'd0);
        check("post_rst_stall",  32'(complexStall_o), 32'd0);
        check("post_rst_starve", 32'(starve_o),       32'd0);
        check("post_rst_ovf",    32'(overflow_o),     32'd0);
        next_cycle();

        // random traffic with scoreboard
        exp_q.delete();
        exp_ovf = 1'b0;
        seq = 100;
        for (int i = 0; i < 130; i++) begin
            if (i < 120) begin
                fl = ($urandom_range(0, 24) == 0);
                sv = ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 9) < 6) begin
                    pkt = p(seq);
                    seq++;
                end else begin
                    pkt = '0;
                end
            end else begin
                fl = 1'b0; sv = 1'b0; pkt = '0;
            end
            drive(fl, sv, pkt);
            @(negedge clk);
            sz = exp_q.size();
            deq_exp = (sz != 0) && !sv && !fl;
            check($sformatf("rnd%0d_count", i), 32'(count_o), 32'(sz));
            check($sformatf("rnd%0d_stall", i), 32'(complexStall_o), 32'(sz == DEPTH));
            check($sformatf("rnd%0d_ovf", i), 32'(overflow_o), 32'(exp_ovf));
            check($sformatf("rnd%0d_valid", i), 32'(wbPacket_o[PKT_W-1]), 32'(deq_exp));
            if (sv) check($sformatf("rnd%0d_sv_quiet", i), 32'(wbPacket_o[PKT_W-1]), 32'd0);
            if (deq_exp) check($sformatf("rnd%0d_data", i), 32'(wbPacket_o), 32'(exp_q.pop_front()));
            if (fl) begin
                exp_q.delete();
            end else if (pkt[PKT_W-1]) begin
                if (sz < DEPTH || deq_exp) exp_q.push_back(pkt);
                else exp_ovf = 1'b1;
            end
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
